axi4_lite_master_arbiter: RTL and testbench

//  Shares one downstream AXI4-Lite master port between N_PORTS upstream requesters (BFM-driven or RTL masters).

---
 rtl/axi4_lite_master_arbiter_pkg.sv | 22 ++
 rtl/axi4_lite_master_arbiter_rr_arbiter.sv | 37 +++
 rtl/axi4_lite_master_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_lite_master_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_master_arbiter_pkg.sv
// rtl/axi4_lite_master_arbiter_pkg.sv - shared types and constants for the AXI4-Lite master arbiter
// Purpose: FSM state encoding and AXI response codes used by the arbiter and its users.
// Ports: none (package).
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_AD = 3'd1,
    WR_B  = 3'd2,
    RD_A  = 3'd3,
    RD_R  = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Value driven on m_wstrb whenever no write data phase is active.
  localparam logic [3:0] WSTRB_IDLE = 4'hf;

endpackage

// File: rtl/axi4_lite_master_arbiter_rr_arbiter.sv
// rtl/axi4_lite_master_arbiter_rr_arbiter.sv - combinational round-robin priority picker
// Purpose: selects the first requesting port at or after the pointer, wrapping N-1 -> 0.
// Ports:
//   i_req      in   N    request vector
//   i_ptr      in   IW   highest-priority port index
//   o_grant    out  IW   selected port index (0 when nothing requests)
//   o_any_req  out  1    at least one request present
module rr_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_grant,
  output logic          o_any_req
);

  logic [IW-1:0] w_idx;

  // Scan from the farthest candidate down to the pointer itself so the
  // last hit written is the one closest to the pointer.
  always_comb begin
    o_grant   = '0;
    o_any_req = 1'b0;
    w_idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_idx]) begin
        o_grant   = w_idx;
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// rtl/axi4_lite_master_arbiter.sv - shares one AXI4-Lite master port among N_PORTS requesters
// Purpose: round-robin grant per transaction, one outstanding write or read at a time.
// Ports:
//   aclk, aresetn              clock; asynchronous active-high reset
//   s_aw*/s_w*/s_b*            per-port write channels (addr/data/strb packed by port)
//   s_ar*/s_r*                 per-port read channels; s_bresp/s_rdata/s_rresp shared
//   m_aw*/m_w*/m_b*/m_ar*/m_r* downstream AXI4-Lite master channels
//   grant_id                   current/last granted port
//   busy                       high whenever a transaction is in progress
module axi4_lite_master_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [N_PORTS*ADDR_W-1:0]     s_awaddr,
  input  logic [N_PORTS-1:0]            s_awvalid,
  output logic [N_PORTS-1:0]            s_awready,
  input  logic [N_PORTS*32-1:0]         s_wdata,
  input  logic [N_PORTS*4-1:0]          s_wstrb,
  input  logic [N_PORTS-1:0]            s_wvalid,
  output logic [N_PORTS-1:0]            s_wready,
  output logic [1:0]                    s_bresp,
  output logic [N_PORTS-1:0]            s_bvalid,
  input  logic [N_PORTS-1:0]            s_bready,
  input  logic [N_PORTS*ADDR_W-1:0]     s_araddr,
  input  logic [N_PORTS-1:0]            s_arvalid,
  output logic [N_PORTS-1:0]            s_arready,
  output logic [31:0]                   s_rdata,
  output logic [1:0]                    s_rresp,
  output logic [N_PORTS-1:0]            s_rvalid,
  input  logic [N_PORTS-1:0]            s_rready,
  output logic [ADDR_W-1:0]             m_awaddr,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [31:0]                   m_wdata,
  output logic [3:0]                    m_wstrb,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  input  logic [1:0]                    m_bresp,
  input  logic                          m_bvalid,
  output logic                          m_bready,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  input  logic [31:0]                   m_rdata,
  input  logic [1:0]                    m_rresp,
  input  logic                          m_rvalid,
  output logic                          m_rready,
  output logic [$clog2(N_PORTS)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IW = $clog2(N_PORTS);

  state_t              r_state;
  logic [IW-1:0]       r_ptr;
  logic [IW-1:0]       r_grant;
  logic                r_aw_done;
  logic                r_w_done;
  // Per-port: 1 means a simultaneous aw+ar request should go to the read next.
  logic [N_PORTS-1:0]  r_rd_next;

  logic [N_PORTS-1:0]  w_req;
  logic [IW-1:0]       w_arb_grant;
  logic                w_any_req;
  logic                w_pick_wr;
  logic [IW-1:0]       w_ptr_next;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_b_hs;
  logic                w_ar_hs;
  logic                w_r_hs;

  logic [ADDR_W-1:0]   w_awaddr_a [N_PORTS];
  logic [ADDR_W-1:0]   w_araddr_a [N_PORTS];
  logic [31:0]         w_wdata_a  [N_PORTS];
  logic [3:0]          w_wstrb_a  [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign w_awaddr_a[i] = s_awaddr[i*ADDR_W +: ADDR_W];
    assign w_araddr_a[i] = s_araddr[i*ADDR_W +: ADDR_W];
    assign w_wdata_a[i]  = s_wdata[i*32 +: 32];
    assign w_wstrb_a[i]  = s_wstrb[i*4 +: 4];
  end

  // A lone wvalid never starts a transaction; only an address does.
  assign w_req = s_awvalid | s_arvalid;

  rr_arbiter #(.N(N_PORTS), .IW(IW)) u_rr (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_grant   (w_arb_grant),
    .o_any_req (w_any_req)
  );

  assign w_pick_wr  = s_awvalid[w_arb_grant] &
                      ~(s_arvalid[w_arb_grant] & r_rd_next[w_arb_grant]);
  assign w_ptr_next = (r_grant == IW'(N_PORTS - 1)) ? '0 : r_grant + 1'b1;

  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid  & m_wready;
  assign w_b_hs  = m_bvalid  & m_bready;
  assign w_ar_hs = m_arvalid & m_arready;
  assign w_r_hs  = m_rvalid  & m_rready;

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_grant   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rd_next <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant                <= w_arb_grant;
            r_rd_next[w_arb_grant] <= w_pick_wr;
            r_state                <= w_pick_wr ? WR_AD : RD_A;
          end
        end
        WR_AD: begin
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
            r_state   <= WR_B;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
          end
        end
        WR_B: begin
          if (w_b_hs) begin
            r_state <= IDLE;
            r_ptr   <= w_ptr_next;
          end
        end
        RD_A: begin
          if (w_ar_hs) r_state <= RD_R;
        end
        RD_R: begin
          if (w_r_hs) begin
            r_state <= IDLE;
            r_ptr   <= w_ptr_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    m_awaddr  = '0;
    m_araddr  = '0;
    m_wdata   = '0;
    m_wstrb   = WSTRB_IDLE;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_arready = '0;
    s_rvalid  = '0;
    case (r_state)
      WR_AD: begin
        m_awvalid          = s_awvalid[r_grant] & ~r_aw_done;
        m_wvalid           = s_wvalid[r_grant] & ~r_w_done;
        m_awaddr           = w_awaddr_a[r_grant];
        m_wdata            = w_wdata_a[r_grant];
        m_wstrb            = w_wstrb_a[r_grant];
        s_awready[r_grant] = m_awready & ~r_aw_done;
        s_wready[r_grant]  = m_wready & ~r_w_done;
      end
      WR_B: begin
        s_bvalid[r_grant] = m_bvalid;
        m_bready          = s_bready[r_grant];
      end
      RD_A: begin
        m_arvalid          = s_arvalid[r_grant];
        m_araddr           = w_araddr_a[r_grant];
        s_arready[r_grant] = m_arready;
      end
      RD_R: begin
        s_rvalid[r_grant] = m_rvalid;
        m_rready          = s_rready[r_grant];
      end
      default: ;
    endcase
  end

  // Shared response buses; only the granted port's valid qualifies them.
  assign s_bresp  = m_bresp;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign grant_id = r_grant;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// tb/tb_axi4_lite_master_arbiter.sv - self-checking bench for axi4_lite_master_arbiter
module tb_axi4_lite_master_arbiter;
  import axi4_lite_arb_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;

  logic            aclk;
  logic            aresetn;
  logic [N*AW-1:0] s_awaddr, s_araddr;
  logic [N-1:0]    s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
  logic [N*32-1:0] s_wdata;
  logic [N*4-1:0]  s_wstrb;
  logic [1:0]      s_bresp, s_rresp;
  logic [31:0]     s_rdata;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic            m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic            m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]     m_wdata, m_rdata;
  logic [3:0]      m_wstrb;
  logic [1:0]      m_bresp, m_rresp;
  logic [0:0]      grant_id;
  logic            busy;

  axi4_lite_master_arbiter #(.N_PORTS(N), .ADDR_W(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .grant_id(grant_id), .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         port;
    bit         is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic push(input int p, input bit is_rd, input logic [31:0] d, input logic [1:0] r);
    exp_t e;
    e.port = p; e.is_rd = is_rd; e.data = d; e.resp = r;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int p, input bit is_rd, input logic [31:0] d,
                        input logic [1:0] r, input logic [N-1:0] vec);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_resp", 64'(p), 64'hFFFF);
    end else begin
      e = sb.pop_front();
      check("sb_port", 64'(p), 64'(e.port));
      check("sb_kind", 64'(is_rd), 64'(e.is_rd));
      check("sb_resp", 64'(r), 64'(e.resp));
      check("sb_valid_onehot", 64'(vec), 64'(1) << p);
      if (is_rd) check("sb_rdata", 64'(d), 64'(e.data));
    end
  endtask

  // Response monitor: pops the scoreboard on every upstream B/R handshake.
  initial begin
    forever begin
      @(negedge aclk);
      for (int p = 0; p < N; p++) begin
        if (s_bvalid[p] && s_bready[p]) sb_pop(p, 1'b0, 32'h0, s_bresp, s_bvalid);
        if (s_rvalid[p] && s_rready[p]) sb_pop(p, 1'b1, s_rdata, s_rresp, s_rvalid);
      end
    end
  end

  // Downstream slave model.
  logic [1:0]  bresp_cfg = RESP_OKAY;
  logic [1:0]  rresp_cfg = RESP_OKAY;
  logic [31:0] sl_awaddr, sl_wdata;
  logic [3:0]  sl_wstrb;
  int          n_aw = 0, n_w = 0, viol_aw = 0, viol_b = 0;

  initial begin
    bit got_aw, got_w, aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] c_awaddr, c_wdata, c_araddr;
    logic [3:0]  c_wstrb;
    got_aw = 0; got_w = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
    forever begin
      @(negedge aclk);
      if (got_aw && m_awvalid) viol_aw++;
      if (m_bready && !m_bvalid && !got_w) viol_b++;
      aw_hs = m_awvalid & m_awready; w_hs = m_wvalid & m_wready;
      b_hs  = m_bvalid & m_bready;   ar_hs = m_arvalid & m_arready;
      r_hs  = m_rvalid & m_rready;
      c_awaddr = m_awaddr; c_wdata = m_wdata; c_wstrb = m_wstrb; c_araddr = m_araddr;
      @(posedge aclk); #1;
      if (aresetn) begin
        got_aw = 0; got_w = 0;
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
      end else begin
        if (aw_hs) begin got_aw = 1; sl_awaddr = c_awaddr; n_aw++; end
        if (w_hs)  begin got_w = 1; sl_wdata = c_wdata; sl_wstrb = c_wstrb; n_w++; end
        if (b_hs)  m_bvalid = 0;
        if (r_hs)  m_rvalid = 0;
        if (got_aw && got_w) begin
          m_bvalid = 1; m_bresp = bresp_cfg; got_aw = 0; got_w = 0;
        end
        if (ar_hs) begin m_rvalid = 1; m_rdata = rd_fn(c_araddr); m_rresp = rresp_cfg; end
        m_awready = !got_aw;
        m_wready  = !got_w;
        m_arready = !m_rvalid;
      end
    end
  end

  // Upstream write; with hold_b the task returns at the negedge where bvalid is first seen.
  task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] st, input int wdly, input bit hold_b);
    bit aw_hs, w_hs, b_hs, done;
    int n;
    done = 0; n = 0;
    s_awaddr[p*AW +: AW] = a;
    s_wdata[p*32 +: 32]  = d;
    s_wstrb[p*4 +: 4]    = st;
    s_awvalid[p] = 1'b1;
    s_bready[p]  = !hold_b;
    if (wdly == 0) s_wvalid[p] = 1'b1;
    while (!done && n < 200) begin
      @(negedge aclk);
      aw_hs = s_awvalid[p] & s_awready[p];
      w_hs  = s_wvalid[p] & s_wready[p];
      b_hs  = s_bvalid[p] & s_bready[p];
      if (hold_b && s_bvalid[p]) begin
        done = 1;
      end else begin
        @(posedge aclk); #1;
        n++;
        if (aw_hs) s_awvalid[p] = 1'b0;
        if (w_hs)  s_wvalid[p]  = 1'b0;
        if (b_hs) begin s_bready[p] = 1'b0; done = 1; end
        if (n == wdly) s_wvalid[p] = 1'b1;
      end
    end
    if (!done) check("wr_timeout", 64'(p), 64'hFFFF);
  endtask

  task automatic rd(input int p, input logic [31:0] a);
    bit ar_hs, r_hs, done;
    int n;
    done = 0; n = 0;
    s_araddr[p*AW +: AW] = a;
    s_arvalid[p] = 1'b1;
    s_rready[p]  = 1'b1;
    while (!done && n < 200) begin
      @(negedge aclk);
      ar_hs = s_arvalid[p] & s_arready[p];
      r_hs  = s_rvalid[p] & s_rready[p];
      @(posedge aclk); #1;
      n++;
      if (ar_hs) s_arvalid[p] = 1'b0;
      if (r_hs) begin s_rready[p] = 1'b0; done = 1; end
    end
    if (!done) check("rd_timeout", 64'(p), 64'hFFFF);
  endtask

  task automatic clear_inputs();
    s_awaddr = '0; s_awvalid = '0; s_wdata = '0; s_wstrb = '0; s_wvalid = '0;
    s_bready = '0; s_araddr = '0; s_arvalid = '0; s_rready = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int aw0, w0;
    aresetn = 1'b1;
    clear_inputs();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_busy", 64'(busy), 0);
    check("rst_grant", 64'(grant_id), 0);
    check("rst_m_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 0);
    check("rst_m_wstrb", 64'(m_wstrb), 64'hf);
    check("rst_m_addr_data", 64'(m_awaddr | m_araddr | m_wdata), 0);
    check("rst_s_handshake", 64'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 0);
    @(posedge aclk); #1 aresetn = 1'b0;

    // Lone wvalid must not start a transaction.
    s_wdata[31:0] = 32'h1234_5678; s_wvalid[0] = 1'b1;
    repeat (3) @(negedge aclk);
    check("wvalid_only_busy", 64'(busy), 0);
    check("wvalid_only_wready", 64'(s_wready), 0);
    @(posedge aclk); #1 s_wvalid[0] = 1'b0;

    // 1: single write from port0.
    aw0 = n_aw; w0 = n_w;
    push(0, 1'b0, 32'h0, RESP_OKAY);
    wr(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hf, 0, 1'b0);
    check("t1_awaddr", 64'(sl_awaddr), 64'h10);
    check("t1_wdata", 64'(sl_wdata), 64'hDEAD_BEEF);
    check("t1_aw_count", 64'(n_aw - aw0), 1);
    check("t1_w_count", 64'(n_w - w0), 1);

    // 3: port1 write with W three cycles behind AW; DECERR forwarded.
    aw0 = n_aw; w0 = n_w;
    bresp_cfg = RESP_DECERR;
    push(1, 1'b0, 32'h0, RESP_DECERR);
    wr(1, 32'h0000_0020, 32'hCAFE_F00D, 4'hA, 3, 1'b0);
    bresp_cfg = RESP_OKAY;
    check("t3_wstrb", 64'(sl_wstrb), 64'hA);
    check("t3_wdata", 64'(sl_wdata), 64'hCAFE_F00D);
    check("t3_aw_count", 64'(n_aw - aw0), 1);
    check("t3_aw_after_hs", 64'(viol_aw), 0);
    check("t3_early_wr_b", 64'(viol_b), 0);

    // 6: SLVERR read on port1, plus arbitration latency.
    rresp_cfg = RESP_SLVERR;
    push(1, 1'b1, rd_fn(32'h500), RESP_SLVERR);
    fork
      rd(1, 32'h500);
      begin
        @(negedge aclk);
        check("t6_lat_cycle0", 64'({busy, m_arvalid}), 0);
        @(negedge aclk);
        check("t6_lat_cycle1", 64'({grant_id, m_arvalid}), 64'b11);
      end
    join
    rresp_cfg = RESP_OKAY;
    @(negedge aclk);
    check("t6_idle_after", 64'(busy), 0);

    // Reset pulse so the next scenario starts from pointer 0.
    @(posedge aclk); #1 aresetn = 1'b1;
    @(posedge aclk); #1 aresetn = 1'b0;
    @(negedge aclk);
    check("pulse_grant", 64'(grant_id), 0);

    // 2: both ports reading back-to-back -> 0,1,0,1.
    push(0, 1'b1, rd_fn(32'h100), RESP_OKAY);
    push(1, 1'b1, rd_fn(32'h204), RESP_OKAY);
    push(0, 1'b1, rd_fn(32'h108), RESP_OKAY);
    push(1, 1'b1, rd_fn(32'h20C), RESP_OKAY);
    @(posedge aclk); #1;
    fork
      begin rd(0, 32'h100); rd(0, 32'h108); end
      begin rd(1, 32'h204); rd(1, 32'h20C); end
    join

    // 4: port0 write+read together, port1 read -> p0 W, p1 R, p0 R.
    push(0, 1'b0, 32'h0, RESP_OKAY);
    push(1, 1'b1, rd_fn(32'h240), RESP_OKAY);
    push(0, 1'b1, rd_fn(32'h140), RESP_OKAY);
    fork
      wr(0, 32'h0000_0030, 32'h0BAD_F00D, 4'hf, 0, 1'b0);
      rd(0, 32'h140);
      rd(1, 32'h240);
    join
    check("t4_wdata", 64'(sl_wdata), 64'h0BAD_F00D);

    // 5: reset while port0 sits in WR_B with m_bvalid high.
    wr(0, 32'h0000_0040, 32'h5555_AAAA, 4'hf, 0, 1'b1);
    check("t5_pre_bvalid", 64'({m_bvalid, s_bvalid}), 64'b101);
    #1 aresetn = 1'b1;
    #1;
    check("t5_rst_s_valid", 64'({s_bvalid, s_rvalid, s_awready, s_wready, s_arready}), 0);
    check("t5_rst_m_ctrl", 64'({m_bready, m_rready, m_awvalid, m_wvalid, m_arvalid}), 0);
    check("t5_rst_busy", 64'(busy), 0);
    check("t5_rst_grant", 64'(grant_id), 0);
    clear_inputs();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b0;
    push(0, 1'b1, rd_fn(32'h300), RESP_OKAY);
    push(1, 1'b1, rd_fn(32'h400), RESP_OKAY);
    fork
      rd(0, 32'h300);
      rd(1, 32'h400);
    join

    repeat (2) @(negedge aclk);
    check("sb_empty", 64'(sb.size()), 0);
    check("final_aw_after_hs", 64'(viol_aw), 0);
    check("final_early_wr_b", 64'(viol_b), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
